// File: rtl/shapool_job_loader.sv
// Byte-stream job loader and reset sequencer for the shapool mining core.
// Holds one job on the core inputs, releases core reset, and captures the winning nonce.
module shapool_job_loader #(
    parameter int JOB_BYTES    = 46,
    parameter int RESET_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    input  logic         cancel,
    input  logic         result_ack,
    output logic [255:0] sha_state,
    output logic [95:0]  message_head,
    output logic [7:0]   difficulty,
    output logic [7:0]   nonce_start_MSB,
    output logic         core_reset,
    input  logic         core_success,
    input  logic [31:0]  core_nonce,
    output logic         result_valid,
    output logic [31:0]  result_nonce,
    output logic         busy
);
    localparam int         STAGE_W    = JOB_BYTES * 8;
    localparam logic [5:0] LAST_BYTE  = 6'(JOB_BYTES - 1);
    localparam logic [7:0] PRIME_LAST = 8'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {LOAD, PRIME, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [7:0]         prime_q, prime_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               result_valid_q, result_valid_d;
    logic [31:0]        result_nonce_q;
    logic               busy_q;
    logic [255:0]       sha_state_q;
    logic [95:0]        message_head_q;
    logic [7:0]         difficulty_q;
    logic [7:0]         nonce_start_q;
    logic               load_done;
    logic               capture;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        prime_d        = prime_q;
        stage_d        = stage_q;
        result_valid_d = result_valid_q;
        load_done      = 1'b0;
        capture        = 1'b0;
        unique case (state_q)
            LOAD: begin
                // A cancel during loading drops the partial job; no byte is taken that cycle.
                if (cancel) begin
                    cnt_d = '0;
                end else if (byte_valid) begin
                    stage_d = {stage_q[STAGE_W-9:0], byte_in};
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d     = '0;
                        load_done = 1'b1;
                        prime_d   = '0;
                        state_d   = PRIME;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            PRIME: begin
                if (cancel) begin
                    state_d = LOAD;
                end else if (prime_q == PRIME_LAST) begin
                    state_d = RUN;
                end else begin
                    prime_d = prime_q + 8'd1;
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = LOAD;
                end else if (core_success) begin
                    capture        = 1'b1;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: begin
                if (cancel || result_ack) begin
                    result_valid_d = 1'b0;
                    state_d        = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        if (cancel) begin
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= LOAD;
            cnt_q          <= '0;
            prime_q        <= '0;
            stage_q        <= '0;
            result_valid_q <= 1'b0;
            result_nonce_q <= '0;
            busy_q         <= 1'b0;
            sha_state_q    <= '0;
            message_head_q <= '0;
            difficulty_q   <= '0;
            nonce_start_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prime_q        <= prime_d;
            stage_q        <= stage_d;
            result_valid_q <= result_valid_d;
            busy_q         <= (state_d == RUN);
            if (capture) begin
                result_nonce_q <= core_nonce;
            end
            // Job outputs take the staging contents including the byte accepted on this edge.
            if (load_done) begin
                sha_state_q    <= stage_d[367:112];
                message_head_q <= stage_d[111:16];
                difficulty_q   <= stage_d[15:8];
                nonce_start_q  <= stage_d[7:0];
            end
        end
    end

    assign byte_ready      = (state_q == LOAD);
    assign core_reset      = (state_q != RUN);
    assign sha_state       = sha_state_q;
    assign message_head    = message_head_q;
    assign difficulty      = difficulty_q;
    assign nonce_start_MSB = nonce_start_q;
    assign result_valid    = result_valid_q;
    assign result_nonce    = result_nonce_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_shapool_job_loader.sv
// Directed bench for shapool_job_loader: load, prime, capture, cancel and reset scenarios.
module tb_shapool_job_loader;
    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         cancel;
    logic         result_ack;
    logic [255:0] sha_state;
    logic [95:0]  message_head;
    logic [7:0]   difficulty;
    logic [7:0]   nonce_start_MSB;
    logic         core_reset;
    logic         core_success;
    logic [31:0]  core_nonce;
    logic         result_valid;
    logic [31:0]  result_nonce;
    logic         busy;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] SHA_A = 256'hdc6a3b8d_0c69421a_cb1916e1_91ad25d8_bd59f1df_3e3dc1bf_04c6dfbc_fc48d2df;
    localparam logic [95:0]  MSG_A = 96'hdc141787_358b0553_535f0119;
    localparam logic [255:0] SHA_B = 256'h01234567_89abcdef_0f1e2d3c_4b5a6978_87969900_aabbccdd_eeff1122_33445566;
    localparam logic [95:0]  MSG_B = 96'hfeedface_cafebabe_deadbeef;

    shapool_job_loader #(.JOB_BYTES(46), .RESET_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .cancel(cancel), .result_ack(result_ack),
        .sha_state(sha_state), .message_head(message_head), .difficulty(difficulty),
        .nonce_start_MSB(nonce_start_MSB), .core_reset(core_reset),
        .core_success(core_success), .core_nonce(core_nonce),
        .result_valid(result_valid), .result_nonce(result_nonce), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [367:0] obs, input logic [367:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_job(input logic [367:0] job, input bit gaps);
        for (int i = 0; i < 46; i++) begin
            byte_in    = job[367 - 8*i -: 8];
            byte_valid = 1'b1;
            tick();
            if (gaps && (i % 7 == 3)) begin
                byte_valid = 1'b0;
                tick();
                tick();
            end
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; byte_in = '0; byte_valid = 1'b0; cancel = 1'b0;
        result_ack = 1'b0; core_success = 1'b0; core_nonce = '0;
        tick();
        reset = 1'b0;
        check("rst_core_reset", core_reset, 1);
        check("rst_byte_ready", byte_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_nonce", result_nonce, 0);
        check("rst_job", {sha_state, message_head, difficulty, nonce_start_MSB}, 0);

        // Full back-to-back load of job A
        load_job({SHA_A, MSG_A, 8'h03, 8'h00}, 1'b0);
        $display("job A loaded");
        check("a_sha", sha_state, SHA_A);
        check("a_msg", message_head, MSG_A);
        check("a_diff", difficulty, 8'h03);
        check("a_nsm", nonce_start_MSB, 8'h00);
        check("a_prime1_core_reset", core_reset, 1);
        check("a_prime1_byte_ready", byte_ready, 0);
        tick();
        check("a_prime2_core_reset", core_reset, 1);
        check("a_prime2_busy", busy, 0);
        tick();
        check("a_run_core_reset", core_reset, 0);
        check("a_run_busy", busy, 1);

        // Bytes offered during RUN are ignored
        byte_in = 8'h55; byte_valid = 1'b1;
        tick(); tick(); tick();
        byte_valid = 1'b0;
        check("run_byte_ready", byte_ready, 0);
        check("run_sha_kept", sha_state, SHA_A);
        check("run_busy_kept", busy, 1);

        // Result capture and acknowledge
        core_success = 1'b1; core_nonce = 32'h0000_1a2b;
        tick();
        core_success = 1'b0; core_nonce = 32'hffff_ffff;
        $display("capture nonce 00001a2b");
        check("cap_valid", result_valid, 1);
        check("cap_nonce", result_nonce, 32'h0000_1a2b);
        check("cap_core_reset", core_reset, 1);
        check("cap_busy", busy, 0);
        tick();
        check("done_hold_valid", result_valid, 1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("ack_valid", result_valid, 0);
        check("ack_byte_ready", byte_ready, 1);
        check("ack_nonce_kept", result_nonce, 32'h0000_1a2b);
        check("ack_sha_kept", sha_state, SHA_A);

        // Partial load of 20 bytes then cancel
        byte_in = 8'hff; byte_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        byte_valid = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("partial_sha_kept", sha_state, SHA_A);
        check("partial_byte_ready", byte_ready, 1);

        // Fresh job B with stalls in byte_valid
        load_job({SHA_B, MSG_B, 8'h0a, 8'h80}, 1'b1);
        $display("job B loaded with gaps");
        check("b_sha", sha_state, SHA_B);
        check("b_msg", message_head, MSG_B);
        check("b_diff", difficulty, 8'h0a);
        check("b_nsm", nonce_start_MSB, 8'h80);
        tick(); tick();
        check("b_run_busy", busy, 1);

        // Cancel beats a simultaneous core_success
        cancel = 1'b1; core_success = 1'b1; core_nonce = 32'hdead_beef;
        tick();
        cancel = 1'b0; core_success = 1'b0;
        check("cx_valid", result_valid, 0);
        check("cx_nonce_kept", result_nonce, 32'h0000_1a2b);
        check("cx_core_reset", core_reset, 1);
        check("cx_byte_ready", byte_ready, 1);
        check("cx_busy", busy, 0);
        check("cx_sha_kept", sha_state, SHA_B);

        // Reset during RUN
        load_job({SHA_A, MSG_A, 8'h03, 8'h00}, 1'b0);
        tick(); tick();
        check("r_run_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("reset during run");
        check("r_job", {sha_state, message_head, difficulty, nonce_start_MSB}, 0);
        check("r_core_reset", core_reset, 1);
        check("r_byte_ready", byte_ready, 1);
        check("r_busy", busy, 0);
        check("r_nonce", result_nonce, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shapool_job_loader.md
# shapool_job_loader

Upstream/downstream controller for `shapool`. Accepts one mining job as a byte stream, holds it in registers driving the `shapool` job inputs, and sequences the core's reset. It then waits for `success` and captures the winning nonce for readback. It replaces the hand-driven parameter/reset sequencing used in simulation with a synthesizable front end.

## Interface
- `JOB_BYTES`, 46, bytes per job: 32 `sha_state`, 12 `message_head`, 1 difficulty, 1 nonce-start MSB.
- `RESET_CYCLES`, 2, cycles `core_reset` is held after a job loads; must be ≥2, to cover the `difficulty_map` register plus the `shapool` reset.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `byte_in` in 8: job byte, MSB-first stream.
- `byte_valid` in 1: `byte_in` valid.
- `byte_ready` out 1: loader accepts a byte; transfer occurs when `byte_valid & byte_ready`.
- `cancel` in 1: abort current job.
- `result_ack` in 1: consumer has read the result.
- `sha_state` out 256: to `shapool`.
- `message_head` out 96: to `shapool`.
- `difficulty` out 8: to `difficulty_map` (low 4 bits used).
- `nonce_start_MSB` out 8: to `shapool`.
- `core_reset` out 1: drives `shapool` and `difficulty_map` `reset`.
- `core_success` in 1: `shapool` `success`.
- `core_nonce` in 32: `shapool` `nonce`.
- `result_valid` out 1: `result_nonce` holds a found nonce.
- `result_nonce` out 32: captured nonce.
- `busy` out 1: job loaded and core running (state RUN).

## Operation
- States: LOAD, PRIME, RUN, DONE.
- LOAD:
  - `byte_ready`=1 and `core_reset`=1.
  - Each accepted byte shifts into a 368-bit staging register and a 6-bit counter increments.
  - Byte 0 → `sha_state[255:248]`, …, byte 31 → `sha_state[7:0]`.
  - Bytes 32–43 → `message_head[95:0]` MSB-first.
  - Byte 44 → `difficulty`; byte 45 → `nonce_start_MSB`.
  - On acceptance of byte `JOB_BYTES-1`: the staging register is copied to the job output registers on the same edge, the counter clears, and the state goes to PRIME.
- PRIME:
  - `core_reset`=1 and `byte_ready`=0 for exactly `RESET_CYCLES` cycles, then RUN.
- RUN:
  - `core_reset`=0 and `busy`=1.
  - On an edge sampling `core_success`=1: `result_nonce` ← `core_nonce`, `result_valid` ← 1, state → DONE.
- DONE:
  - `core_reset`=1, which freezes the core, and `result_valid`=1.
  - On an edge sampling `result_ack`=1: `result_valid` ← 0, state → LOAD.
- `cancel`:
  - Sampled in PRIME, RUN or DONE: state → LOAD, `result_valid` ← 0, `core_reset`=1.
  - In LOAD: clears the byte counter, discarding a partial job.
  - Cancel wins over a simultaneous `core_success` or `result_ack`.
- Job output registers change only on a completed load or on `reset`. They are stable throughout PRIME/RUN/DONE and retained after DONE.
- `byte_valid` outside LOAD is ignored; no byte is consumed.
- `result_ack` outside DONE is ignored.
- `core_success` outside RUN is ignored.
- `result_nonce` is retained until the next capture; it is cleared only by `reset`.

## Timing
- Reset values:
  - State LOAD, counter 0.
  - All job outputs 0, `result_nonce` 0.
  - `result_valid` 0, `busy` 0.
  - `core_reset` 1, `byte_ready` 1.
- `core_reset` and `byte_ready` decode combinationally from state; all other outputs are registered.
- Load latency:
  - Byte 45 is accepted at edge E; new job outputs are visible after E.
  - `core_reset` is high for cycles E+1..E+`RESET_CYCLES` and goes low from edge E+`RESET_CYCLES`.
- Result latency: `core_success` sampled at edge S gives `result_valid`=1 and a valid `result_nonce` after S, and `core_reset`=1 after S.
- Back-to-back bytes are accepted at one byte per cycle with no bubbles.
- `reset` mid-load or mid-run restores all reset values on that edge; the partial job is discarded.

## Test plan
- Reset: assert `reset` one cycle → all outputs at reset values, `core_reset`=1, `byte_ready`=1.
- Full load: stream `dc6a3b8d…fc48d2df`, `dc141787358b0553535f0119`, `03`, `00` → `sha_state`=`dc6a3b8d_0c69421a_…_fc48d2df`, `message_head`=`dc141787_358b0553_535f0119`, `difficulty`=3, `nonce_start_MSB`=0; `core_reset` high 2 cycles then low, `busy`=1.
- Capture: in RUN, drive `core_success`=1 with `core_nonce`=`0x0000_1a2b` → next cycle `result_valid`=1, `result_nonce`=`0x00001a2b`, `core_reset`=1. Pulse `result_ack` → `result_valid`=0 and `byte_ready`=1.
- Stall/ignore: gaps in `byte_valid` mid-load → same final registers. Bytes sent during RUN → job outputs unchanged.
- Cancel: 20 bytes then `cancel` → counter 0; a fresh 46-byte job loads correctly. `cancel` and `core_success` in the same RUN cycle → LOAD, `result_valid`=0, `result_nonce` unchanged.
- Reset mid-run: `reset` during RUN → job outputs 0, state LOAD, `core_reset`=1.
